// File: rtl/hub_ingress_arbiter_pkg.sv
// rtl/hub_ingress_arbiter_pkg.sv - shared hub ingress constants and arbiter state type
package hub_ingress_arbiter_pkg;

  localparam int SRC_INDEX_WIDTH = 8;
  localparam logic [SRC_INDEX_WIDTH-1:0] UPSTREAM_SRC_INDEX = 8'hFF;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAINING,
    ST_DRAINED
  } arb_state_e;

endpackage

// File: rtl/hub_ingress_arbiter_rr_priority_picker.sv
// rtl/hub_ingress_arbiter_rr_priority_picker.sv - rotating-priority find-first over N requests
module rr_priority_picker
  import hub_ingress_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]               req_i,
  input  logic [PW-1:0]              ptr_i,
  output logic [N-1:0]               gnt_o,
  output logic [SRC_INDEX_WIDTH-1:0] idx_o,
  output logic                       any_o
);

  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0] rot;

  // Rotate so that the channel at ptr_i lands on bit 0; lowest set bit then wins.
  assign rot = N'({req_i, req_i} >> ptr_i);

  always_comb begin
    int off;
    int pos;
    off = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = i;
    end
    pos = int'(ptr_i) + off;
    if (pos >= N) pos = pos - N;
    any_o = |req_i;
    gnt_o = any_o ? (ONE << pos) : '0;
    idx_o = SRC_INDEX_WIDTH'(pos);
  end

endmodule

// File: rtl/hub_ingress_arbiter.sv
// rtl/hub_ingress_arbiter.sv - hub ingress arbiter: upstream-priority with starvation guard, RR downstream, drain handshake
// Optional statistics counters are enabled by defining HUB_ARB_STATS_EN.
module hub_ingress_arbiter
  import hub_ingress_arbiter_pkg::*;
#(
  parameter int HUB_FIFO_WIDTH        = 32,
  parameter int DOWNSTREAM_FIFO_COUNT = 4,
  parameter int MAX_UP_STREAK         = 4
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic [HUB_FIFO_WIDTH-1:0]                       up_in_data,
  input  logic                                            up_in_valid,
  output logic                                            up_in_taken,
  input  logic [DOWNSTREAM_FIFO_COUNT*HUB_FIFO_WIDTH-1:0] dn_in_data,
  input  logic [DOWNSTREAM_FIFO_COUNT-1:0]                dn_in_valid,
  output logic [DOWNSTREAM_FIFO_COUNT-1:0]                dn_in_taken,
  output logic [HUB_FIFO_WIDTH-1:0]                       out_data,
  output logic [7:0]                                      out_index,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  input  logic                                            drain_req,
  output logic                                            drained
`ifdef HUB_ARB_STATS_EN
  ,
  output logic [31:0]                                     stat_up_grants,
  output logic [31:0]                                     stat_dn_grants,
  output logic [31:0]                                     stat_stall_cycles
`endif
);

  localparam int N  = DOWNSTREAM_FIFO_COUNT;
  localparam int W  = HUB_FIFO_WIDTH;
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = $clog2(MAX_UP_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_UP_STREAK);
  localparam logic [SRC_INDEX_WIDTH-1:0] LAST_CH = SRC_INDEX_WIDTH'(N - 1);

  arb_state_e                 state_q, state_d;
  logic                       out_valid_q, out_valid_d;
  logic [W-1:0]               out_data_q, out_data_d;
  logic [SRC_INDEX_WIDTH-1:0] out_index_q, out_index_d;
  logic                       drained_q;
  logic [PW-1:0]              rr_ptr_q, rr_ptr_d;
  logic [SW-1:0]              streak_q, streak_d;

  logic [N-1:0]               pick_gnt;
  logic [SRC_INDEX_WIDTH-1:0] pick_idx;
  logic                       dn_any;
  logic [W-1:0]               dn_sel;
  logic                       can_load, up_win, grant_up, grant_dn;

  rr_priority_picker #(
    .N  (N),
    .PW (PW)
  ) u_picker (
    .req_i (dn_in_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (dn_any)
  );

  always_comb begin
    dn_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (pick_gnt[i]) dn_sel = dn_in_data[i*W +: W];
    end
  end

  // Gating with reset keeps the pop strobes quiet while reset is held.
  assign can_load = reset && (!out_valid_q || out_ready) && (state_q == ST_RUN);
  assign up_win   = up_in_valid && (!dn_any || (streak_q < STREAK_MAX));
  assign grant_up = can_load && up_win;
  assign grant_dn = can_load && !up_win && dn_any;

  assign up_in_taken = grant_up;
  assign dn_in_taken = grant_dn ? pick_gnt : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    rr_ptr_d    = rr_ptr_q;
    streak_d    = streak_q;
    if (grant_up) begin
      out_valid_d = 1'b1;
      out_data_d  = up_in_data;
      out_index_d = UPSTREAM_SRC_INDEX;
      streak_d    = (streak_q == STREAK_MAX) ? streak_q : streak_q + SW'(1);
    end else if (grant_dn) begin
      out_valid_d = 1'b1;
      out_data_d  = dn_sel;
      out_index_d = pick_idx;
      streak_d    = '0;
      rr_ptr_d    = (pick_idx == LAST_CH) ? '0 : PW'(pick_idx + 8'd1);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (drain_req) state_d = ST_DRAINING;
      end
      ST_DRAINING: begin
        if (!drain_req) state_d = ST_RUN;
        else if (!out_valid_q || out_ready) state_d = ST_DRAINED;
      end
      ST_DRAINED: begin
        if (!drain_req) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      drained_q   <= 1'b0;
      rr_ptr_q    <= '0;
      streak_q    <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      drained_q   <= (state_d == ST_DRAINED);
      rr_ptr_q    <= rr_ptr_d;
      streak_q    <= streak_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign drained   = drained_q;

`ifdef HUB_ARB_STATS_EN
  logic [31:0] stat_up_q, stat_dn_q, stat_stall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_up_q    <= '0;
      stat_dn_q    <= '0;
      stat_stall_q <= '0;
    end else begin
      if (grant_up) stat_up_q <= stat_up_q + 32'd1;
      if (grant_dn) stat_dn_q <= stat_dn_q + 32'd1;
      if (out_valid_q && !out_ready) stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign stat_up_grants    = stat_up_q;
  assign stat_dn_grants    = stat_dn_q;
  assign stat_stall_cycles = stat_stall_q;
`endif

endmodule

// File: tb/tb_hub_ingress_arbiter.sv
// tb/tb_hub_ingress_arbiter.sv - scoreboard bench for hub_ingress_arbiter (N=4, W=16, MAX_UP_STREAK=3)
module tb_hub_ingress_arbiter;

  localparam int N    = 4;
  localparam int W    = 16;
  localparam int MAXS = 3;

  logic           clk;
  logic           reset;
  logic [W-1:0]   up_in_data;
  logic           up_in_valid;
  logic           up_in_taken;
  logic [N*W-1:0] dn_in_data;
  logic [N-1:0]   dn_in_valid;
  logic [N-1:0]   dn_in_taken;
  logic [W-1:0]   out_data;
  logic [7:0]     out_index;
  logic           out_valid;
  logic           out_ready;
  logic           drain_req;
  logic           drained;
`ifdef HUB_ARB_STATS_EN
  logic [31:0]    stat_up_grants;
  logic [31:0]    stat_dn_grants;
  logic [31:0]    stat_stall_cycles;
`endif

  hub_ingress_arbiter #(
    .HUB_FIFO_WIDTH        (W),
    .DOWNSTREAM_FIFO_COUNT (N),
    .MAX_UP_STREAK         (MAXS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .up_in_data  (up_in_data),
    .up_in_valid (up_in_valid),
    .up_in_taken (up_in_taken),
    .dn_in_data  (dn_in_data),
    .dn_in_valid (dn_in_valid),
    .dn_in_taken (dn_in_taken),
    .out_data    (out_data),
    .out_index   (out_index),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .drain_req   (drain_req),
    .drained     (drained)
`ifdef HUB_ARB_STATS_EN
    ,
    .stat_up_grants    (stat_up_grants),
    .stat_dn_grants    (stat_dn_grants),
    .stat_stall_cycles (stat_stall_cycles)
`endif
  );

  typedef struct packed {
    logic [15:0] data;
    logic [7:0]  idx;
  } exp_t;

  exp_t        expq[$];
  exp_t        mon_e;
  logic [15:0] upq[$];
  logic [15:0] dnq[N][$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        last_up;
  logic [N-1:0] last_dn;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_push(input logic [15:0] d, input logic [7:0] i);
    exp_t e;
    e.data = d;
    e.idx  = i;
    expq.push_back(e);
  endtask

  // One clock: present FIFO heads at negedge, record the pops the DUT issues.
  task automatic cycle(input logic rdy, input logic drn);
    int cnt;
    @(negedge clk);
    out_ready   = rdy;
    drain_req   = drn;
    up_in_valid = (upq.size() > 0);
    up_in_data  = (upq.size() > 0) ? upq[0] : '0;
    for (int i = 0; i < N; i++) begin
      dn_in_valid[i]       = (dnq[i].size() > 0);
      dn_in_data[i*W +: W] = (dnq[i].size() > 0) ? dnq[i][0] : '0;
    end
    #1;
    last_up = up_in_taken;
    last_dn = dn_in_taken;
    cnt = int'(up_in_taken) + $countones(dn_in_taken);
    chk("taken_at_most_one", 32'(cnt > 1), 0);
    if (up_in_taken) begin
      chk("up_taken_while_empty", 32'(upq.size() == 0), 0);
      if (upq.size() > 0) void'(upq.pop_front());
    end
    for (int i = 0; i < N; i++) begin
      if (dn_in_taken[i]) begin
        chk("dn_taken_while_empty", 32'(dnq[i].size() == 0), 0);
        if (dnq[i].size() > 0) void'(dnq[i].pop_front());
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (reset && out_valid && out_ready) begin
        if (expq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got data %0h index %0h, none expected", out_data, out_index);
        end else begin
          mon_e = expq.pop_front();
          chk("out_data", 32'(out_data), 32'(mon_e.data));
          chk("out_index", 32'(out_index), 32'(mon_e.idx));
        end
      end
    end
  end

  initial begin
    reset       = 1'b0;
    out_ready   = 1'b0;
    drain_req   = 1'b0;
    up_in_valid = 1'b1;
    up_in_data  = 16'h1234;
    dn_in_valid = 4'hF;
    dn_in_data  = '1;
    last_up     = 1'b0;
    last_dn     = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_index", 32'(out_index), 0);
    chk("rst_drained", 32'(drained), 0);
    chk("rst_up_taken", 32'(up_in_taken), 0);
    chk("rst_dn_taken", 32'(dn_in_taken), 0);
    @(negedge clk);
    up_in_valid = 1'b0;
    dn_in_valid = '0;
    reset       = 1'b1;

    // Round-robin over channels 1 and 3 with wrap.
    dnq[1].push_back(16'h1101);
    dnq[1].push_back(16'h1102);
    dnq[3].push_back(16'h3301);
    exp_push(16'h1101, 8'd1);
    exp_push(16'h3301, 8'd3);
    exp_push(16'h1102, 8'd1);
    cycle(1'b1, 1'b0);
    chk("rr_first", 32'(last_dn), 32'h2);
    cycle(1'b1, 1'b0);
    chk("rr_second", 32'(last_dn), 32'h8);
    cycle(1'b1, 1'b0);
    chk("rr_wrap", 32'(last_dn), 32'h2);
    repeat (2) cycle(1'b1, 1'b0);

    // Starvation guard: three upstream grants then channel 0.
    for (int i = 0; i < 6; i++) upq.push_back(16'hF000 + 16'(i));
    dnq[0].push_back(16'h0A00);
    dnq[0].push_back(16'h0A01);
    exp_push(16'hF000, 8'hFF);
    exp_push(16'hF001, 8'hFF);
    exp_push(16'hF002, 8'hFF);
    exp_push(16'h0A00, 8'd0);
    exp_push(16'hF003, 8'hFF);
    exp_push(16'hF004, 8'hFF);
    exp_push(16'hF005, 8'hFF);
    exp_push(16'h0A01, 8'd0);
    repeat (10) cycle(1'b1, 1'b0);

    // Back-pressure hold, then reload in the same edge as acceptance.
    dnq[2].push_back(16'hABCD);
    dnq[2].push_back(16'h2222);
    exp_push(16'hABCD, 8'd2);
    exp_push(16'h2222, 8'd2);
    cycle(1'b0, 1'b0);
    chk("stall_grant", 32'(last_dn), 32'h4);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0);
      chk("stall_no_taken", 32'({last_up, last_dn}), 0);
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_data", 32'(out_data), 32'hABCD);
    end
    cycle(1'b1, 1'b0);
    chk("no_bubble_reload", 32'(last_dn), 32'h4);
    cycle(1'b1, 1'b0);
    chk("after_reload_idle", 32'({last_up, last_dn}), 0);
    cycle(1'b1, 1'b0);
    chk("output_emptied", 32'(out_valid), 0);

    // Drain while a message is held.
    dnq[0].push_back(16'h5555);
    dnq[1].push_back(16'h6666);
    exp_push(16'h5555, 8'd0);
    exp_push(16'h6666, 8'd1);
    cycle(1'b0, 1'b0);
    chk("drain_pre_grant", 32'(last_dn), 32'h1);
    cycle(1'b0, 1'b1);
    chk("drain_req_cycle_taken", 32'({last_up, last_dn}), 0);
    chk("drain_req_cycle_drained", 32'(drained), 0);
    cycle(1'b0, 1'b1);
    chk("draining_taken", 32'({last_up, last_dn}), 0);
    chk("draining_drained", 32'(drained), 0);
    cycle(1'b1, 1'b1);
    chk("draining_accept_taken", 32'({last_up, last_dn}), 0);
    chk("draining_accept_drained", 32'(drained), 0);
    cycle(1'b1, 1'b1);
    chk("drained_set", 32'(drained), 1);
    chk("drained_taken", 32'({last_up, last_dn}), 0);
    cycle(1'b1, 1'b0);
    chk("drained_held_on_release", 32'(drained), 1);
    chk("release_cycle_taken", 32'({last_up, last_dn}), 0);
    cycle(1'b1, 1'b0);
    chk("drained_cleared", 32'(drained), 0);
    chk("grant_resumes", 32'(last_dn), 32'h2);
    cycle(1'b1, 1'b0);

    // Asynchronous reset while a message is held.
    for (int i = 0; i < N; i++) begin
      dnq[i].push_back(16'h7000 + 16'(i * 256));
      dnq[i].push_back(16'h7001 + 16'(i * 256));
    end
    cycle(1'b0, 1'b0);
    chk("pre_reset_grant", 32'(last_dn), 32'h4);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_drained", 32'(drained), 0);
    chk("async_rst_up_taken", 32'(up_in_taken), 0);
    chk("async_rst_dn_taken", 32'(dn_in_taken), 0);
    #1;
    reset = 1'b1;
    exp_push(16'h7000, 8'd0);
    exp_push(16'h7100, 8'd1);
    exp_push(16'h7201, 8'd2);
    exp_push(16'h7300, 8'd3);
    exp_push(16'h7001, 8'd0);
    exp_push(16'h7101, 8'd1);
    exp_push(16'h7301, 8'd3);
    cycle(1'b1, 1'b0);
    chk("post_reset_rr_ch0", 32'(last_dn), 32'h1);
    repeat (8) cycle(1'b1, 1'b0);

`ifdef HUB_ARB_STATS_EN
    @(negedge clk);
    reset = 1'b0;
    #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) upq.push_back(16'hF100 + 16'(i));
    dnq[0].push_back(16'h0B00);
    dnq[0].push_back(16'h0B01);
    exp_push(16'hF100, 8'hFF);
    exp_push(16'hF101, 8'hFF);
    exp_push(16'hF102, 8'hFF);
    exp_push(16'h0B00, 8'd0);
    exp_push(16'h0B01, 8'd0);
    repeat (5) cycle(1'b0, 1'b0);
    repeat (6) cycle(1'b1, 1'b0);
    chk("stat_up_grants", stat_up_grants, 3);
    chk("stat_dn_grants", stat_dn_grants, 2);
    chk("stat_stall_cycles", stat_stall_cycles, 4);
`endif

    for (int i = 0; i < 20 && expq.size() > 0; i++) cycle(1'b1, 1'b0);
    chk("scoreboard_empty", 32'(expq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
